axis_bit_merger: RTL and testbench
==================================

// Module: axis_bit_merger
// PURPOSE
// - AXI-Stream bit merger. Receive-side counterpart of the bit-packetizer, which splits beats at PKT_BITS boundaries.
// - Accepts 16-bit beats whose s_tkeep gives the count of valid LSB bits (0..16).
// - Concatenates the valid bits LSB-first and emits dense 16-bit words (m_tkeep=16).
// - On s_tlast, flushes the partial remainder with m_tlast=1 and checks packet length against PKT_BITS.
// PARAMETERS
// - PKT_BITS   40   expected valid bits per packet; used only for the len_err check
// - CHECK_LEN  1    1: enable the len_err check; 0: len_err is tied to 0
// PORTS
// - clk        in   1   clock, rising edge
// - reset_n    in   1   synchronous, active-low reset
// - s_tdata    in   16  input data; valid bits are s_tdata[s_tkeep-1:0]
// - s_tkeep    in   5   number of valid input bits (0..16; 17..31 illegal)
// - s_tvalid   in   1   input beat valid
// - s_tlast    in   1   last beat of input packet
// - s_tready   out  1   input ready
// - m_tdata    out  16  merged output word
// - m_tkeep    out  5   valid output bits (16, or remainder 0..15 on flush)
// - m_tvalid   out  1   output valid
// - m_tlast    out  1   last word of packet
// - m_tready   in   1   downstream ready
// - len_err    out  1   1-cycle pulse: packet bit count != PKT_BITS, or an illegal s_tkeep was seen
// BEHAVIOUR
// - Reset (reset_n=0 at a clk edge):
//   - state=ACCEPT; acc[31:0]=0; lvl[5:0]=0; pend_last=0; pkt_cnt=0; err_flag=0.
//   - Outputs: m_tvalid=0, m_tdata=0, m_tkeep=0, m_tlast=0, len_err=0.
//   - s_tready=0 while reset_n=0; =1 on the first cycle after release.
// - Reset mid-operation discards acc and any pending word. No partial output after reset.
// - Handshakes:
//   - Transfer on valid&ready on either side.
//   - m_* hold stable while m_tvalid=1 and m_tready=0.
//   - s_tready = (state==ACCEPT); it is a function of state only, never of m_tready.
// - Bit count k = min(s_tkeep,16). s_tkeep>16 sets err_flag.
//   - Masked data d = s_tdata & ((1<<k)-1).
// - ACCEPT, on s_tvalid:
//   - acc |= d<<lvl; lvl += k (max 15+16=31, no overflow); pkt_cnt += k (16-bit, saturating); pend_last = s_tlast.
//   - Next state:
//     - lvl_new>=16 -> EMIT
//     - else if s_tlast -> FLUSH (also when lvl_new==0)
//     - else stay in ACCEPT.
//   - k=0 non-last beat: accepted, no effect except the handshake.
// - EMIT: m_tvalid=1, m_tdata=acc[15:0], m_tkeep=16.
//   - m_tlast = pend_last && (lvl==16).
//   - On m_tready: acc >>= 16; lvl -= 16.
//   - Next state:
//     - pend_last && lvl_after>0 -> FLUSH
//     - pend_last && lvl_after==0 -> ACCEPT; this word ends the packet.
//     - otherwise -> ACCEPT.
//   - At most one EMIT per input beat, because lvl_after<16 always.
// - FLUSH: m_tvalid=1, m_tdata=acc[15:0] (bits >= lvl are 0), m_tkeep=lvl, m_tlast=1.
//   - Zero-length tail gives m_tkeep=0, m_tlast=1, so framing is preserved.
//   - On m_tready: acc=0, lvl=0, pend_last=0 -> ACCEPT.
// - Packet end = handshake of the m_tlast=1 word.
//   - Next cycle: len_err = CHECK_LEN & ((pkt_cnt != PKT_BITS) | err_flag).
//   - At packet end, pkt_cnt and err_flag clear.
// - Latency and throughput:
//   - m_tvalid rises exactly 1 cycle after the accepting edge. Outputs are registered from state/acc.
//   - Throughput is 1 input beat per 2 cycles when every beat emits. No input/output overlap (no bypass).
// TESTING
// - PKT_BITS=40; beats (k16 0xAAAA),(k16 0x5555),(k8 0x00C3,last)
//   -> 0xAAAA/k16/l0, 0x5555/k16/l0, 0x00C3/k8/l1; len_err stays 0.
// - Straddle: (k12 0x0ABC),(k12 0x0DEF,last)
//   -> 0xFABC/k16/l0, then 0x00DE/k8/l1; len_err pulses (24 != 40).
// - Exact fill: (k8 0x0012),(k8 0x0034,last)
//   -> single word 0x3412/k16/l1; no FLUSH beat.
// - Backpressure: m_tready=0 for 5 cycles during EMIT
//   -> m_tdata/m_tkeep/m_tlast stable; s_tready=0; no data lost or duplicated.
// - Illegal keep: (k20 0xFFFF,last) with PKT_BITS=16
//   -> 0xFFFF/k16/l1; len_err pulses 1 cycle after the handshake.
// - Reset mid-packet in EMIT
//   -> next cycle m_tvalid=0; the following 40-bit packet reproduces test 1 exactly.

Source files
------------

// File: rtl/axis_bit_merger.sv
// AXI-Stream bit merger: packs the valid LSB bits of each input beat into dense
// 16-bit output words, flushes the remainder on tlast and flags bad packet lengths.
module axis_bit_merger #(
  parameter int unsigned PKT_BITS  = 40,
  parameter int unsigned CHECK_LEN = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] s_tdata,
  input  logic [4:0]  s_tkeep,
  input  logic        s_tvalid,
  input  logic        s_tlast,
  output logic        s_tready,
  output logic [15:0] m_tdata,
  output logic [4:0]  m_tkeep,
  output logic        m_tvalid,
  output logic        m_tlast,
  input  logic        m_tready,
  output logic        len_err
);

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    EMIT   = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [5:0]  lvl_q, lvl_d;
  logic        pend_last_q, pend_last_d;
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic        err_flag_q, err_flag_d;
  logic        len_err_q, len_err_d;

  logic [4:0]  bit_cnt;
  logic [31:0] beat_bits;
  logic [16:0] cnt_sum;
  logic        word_last;
  logic        len_bad;
  logic        pkt_end;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ACCEPT;
      acc_q       <= '0;
      lvl_q       <= '0;
      pend_last_q <= 1'b0;
      pkt_cnt_q   <= '0;
      err_flag_q  <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      lvl_q       <= lvl_d;
      pend_last_q <= pend_last_d;
      pkt_cnt_q   <= pkt_cnt_d;
      err_flag_q  <= err_flag_d;
      len_err_q   <= len_err_d;
    end
  end

  always_comb begin
    bit_cnt     = (s_tkeep > 5'd16) ? 5'd16 : s_tkeep;
    beat_bits   = {16'h0000, s_tdata} & ((32'd1 << bit_cnt) - 32'd1);
    cnt_sum     = {1'b0, pkt_cnt_q} + {12'h000, bit_cnt};
    word_last   = pend_last_q && (lvl_q == 6'd16);
    len_bad     = (pkt_cnt_q != 16'(PKT_BITS)) || err_flag_q;
    state_d     = state_q;
    acc_d       = acc_q;
    lvl_d       = lvl_q;
    pend_last_d = pend_last_q;
    pkt_cnt_d   = pkt_cnt_q;
    err_flag_d  = err_flag_q;
    len_err_d   = 1'b0;
    pkt_end     = 1'b0;
    unique case (state_q)
      ACCEPT: begin
        if (s_tvalid) begin
          acc_d       = acc_q | (beat_bits << lvl_q);
          lvl_d       = lvl_q + {1'b0, bit_cnt};
          pkt_cnt_d   = cnt_sum[16] ? '1 : cnt_sum[15:0];
          err_flag_d  = err_flag_q | (s_tkeep > 5'd16);
          pend_last_d = s_tlast;
          if (lvl_d >= 6'd16)
            state_d = EMIT;
          else if (s_tlast)
            state_d = FLUSH;
        end
      end
      EMIT: begin
        if (m_tready) begin
          acc_d = acc_q >> 16;
          lvl_d = lvl_q - 6'd16;
          if (word_last) begin
            // exact fill: the full word already carried tlast, so skip the empty tail
            pend_last_d = 1'b0;
            pkt_end     = 1'b1;
            state_d     = ACCEPT;
          end else if (pend_last_q) begin
            state_d = FLUSH;
          end else begin
            state_d = ACCEPT;
          end
        end
      end
      FLUSH: begin
        if (m_tready) begin
          acc_d       = '0;
          lvl_d       = '0;
          pend_last_d = 1'b0;
          pkt_end     = 1'b1;
          state_d     = ACCEPT;
        end
      end
      default: state_d = ACCEPT;
    endcase
    if (pkt_end) begin
      len_err_d  = (CHECK_LEN != 0) && len_bad;
      pkt_cnt_d  = '0;
      err_flag_d = 1'b0;
    end
  end

  always_comb begin
    s_tready = reset_n && (state_q == ACCEPT);
    m_tvalid = (state_q != ACCEPT);
    m_tdata  = m_tvalid ? acc_q[15:0] : '0;
    m_tkeep  = '0;
    m_tlast  = 1'b0;
    unique case (state_q)
      EMIT: begin
        m_tkeep = 5'd16;
        m_tlast = word_last;
      end
      FLUSH: begin
        m_tkeep = lvl_q[4:0];
        m_tlast = 1'b1;
      end
      default: ;
    endcase
    len_err = len_err_q;
  end

endmodule

// File: tb/tb_axis_bit_merger.sv
// Bench for axis_bit_merger: two instances (PKT_BITS 40 and 16) share all inputs;
// directed packets plus random packets checked against a bit-queue model.
module tb_axis_bit_merger;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] s_tdata;
  logic [4:0]  s_tkeep;
  logic        s_tvalid, s_tlast, m_tready;
  logic        s_tready, m_tvalid, m_tlast, len_err;
  logic [15:0] m_tdata;
  logic [4:0]  m_tkeep;
  logic        s_tready16, m_tvalid16, m_tlast16, len_err16;
  logic [15:0] m_tdata16;
  logic [4:0]  m_tkeep16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axis_bit_merger #(.PKT_BITS(40), .CHECK_LEN(1)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tready(m_tready), .len_err(len_err)
  );

  axis_bit_merger #(.PKT_BITS(16), .CHECK_LEN(1)) u_dut16 (
    .clk(clk), .reset_n(reset_n),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready16),
    .m_tdata(m_tdata16), .m_tkeep(m_tkeep16), .m_tvalid(m_tvalid16), .m_tlast(m_tlast16),
    .m_tready(m_tready), .len_err(len_err16)
  );

  // Starts and ends on a falling edge; returns just after the accepting edge.
  task automatic send_beat(input logic [15:0] d, input logic [4:0] k, input logic last);
    int unsigned n = 0;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = last;
    s_tvalid = 1'b1;
    while (!(s_tready && s_tready16) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!(s_tready && s_tready16)) begin
      total++;
      bad++;
      $display("FAIL send_timeout: s_tready=%b/%b required 1/1", s_tready, s_tready16);
    end else begin
      @(negedge clk);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // Waits for a word, stalls, then takes it; returns just after the handshake edge.
  task automatic get_word(input int unsigned stall, output logic [21:0] w, output logic [21:0] w16);
    int unsigned n = 0;
    w   = '0;
    w16 = '0;
    while (!(m_tvalid && m_tvalid16) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!(m_tvalid && m_tvalid16)) begin
      total++;
      bad++;
      $display("FAIL word_timeout: m_tvalid=%b/%b required 1/1", m_tvalid, m_tvalid16);
    end else begin
      repeat (stall) @(negedge clk);
      w   = {m_tdata, m_tkeep, m_tlast};
      w16 = {m_tdata16, m_tkeep16, m_tlast16};
      m_tready = 1'b1;
      @(negedge clk);
      m_tready = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [24:0] obs;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    obs = {s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, len_err};
    total++;
    if (obs !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h required 0", obs);
    end
    total++;
    if ({s_tready16, m_tvalid16, m_tlast16, len_err16} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_outputs16: got %b required 0000", {s_tready16, m_tvalid16, m_tlast16, len_err16});
    end
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if (s_tready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready: got %b required 1", s_tready);
    end
  endtask

  task automatic test_basic();
    logic [21:0] w, w16;
    send_beat(16'hAAAA, 5'd16, 1'b0);
    total++;
    if (m_tvalid !== 1'b1) begin
      bad++;
      $display("FAIL basic_latency: m_tvalid=%b required 1", m_tvalid);
    end
    get_word(0, w, w16);
    total++;
    if ({w, w16} !== {16'hAAAA, 5'd16, 1'b0, 16'hAAAA, 5'd16, 1'b0}) begin
      bad++;
      $display("FAIL basic_w0: got %h/%h required aaaa/16/0", w, w16);
    end
    send_beat(16'h5555, 5'd16, 1'b0);
    get_word(1, w, w16);
    total++;
    if ({w, w16} !== {16'h5555, 5'd16, 1'b0, 16'h5555, 5'd16, 1'b0}) begin
      bad++;
      $display("FAIL basic_w1: got %h/%h required 5555/16/0", w, w16);
    end
    send_beat(16'h00C3, 5'd8, 1'b1);
    get_word(0, w, w16);
    total++;
    if ({w, w16} !== {16'h00C3, 5'd8, 1'b1, 16'h00C3, 5'd8, 1'b1}) begin
      bad++;
      $display("FAIL basic_w2: got %h/%h required 00c3/8/1", w, w16);
    end
    total++;
    if ({len_err, len_err16} !== 2'b01) begin
      bad++;
      $display("FAIL basic_len_err: got %b required 01", {len_err, len_err16});
    end
    @(negedge clk);
    total++;
    if ({len_err, len_err16, m_tvalid} !== 3'b000) begin
      bad++;
      $display("FAIL basic_idle: got %b required 000", {len_err, len_err16, m_tvalid});
    end
  endtask

  task automatic test_straddle();
    logic [21:0] w, w16;
    send_beat(16'h0ABC, 5'd12, 1'b0);
    total++;
    if (m_tvalid !== 1'b0) begin
      bad++;
      $display("FAIL straddle_no_word: m_tvalid=%b required 0", m_tvalid);
    end
    send_beat(16'h0DEF, 5'd12, 1'b1);
    get_word(0, w, w16);
    total++;
    if (w !== {16'hFABC, 5'd16, 1'b0}) begin
      bad++;
      $display("FAIL straddle_w0: got %h required fabc/16/0", w);
    end
    get_word(0, w, w16);
    total++;
    if (w !== {16'h00DE, 5'd8, 1'b1}) begin
      bad++;
      $display("FAIL straddle_w1: got %h required 00de/8/1", w);
    end
    total++;
    if ({len_err, len_err16} !== 2'b11) begin
      bad++;
      $display("FAIL straddle_len_err: got %b required 11", {len_err, len_err16});
    end
  endtask

  task automatic test_exact_fill();
    logic [21:0] w, w16;
    send_beat(16'h0012, 5'd8, 1'b0);
    send_beat(16'h0034, 5'd8, 1'b1);
    get_word(2, w, w16);
    total++;
    if (w !== {16'h3412, 5'd16, 1'b1}) begin
      bad++;
      $display("FAIL exact_w0: got %h required 3412/16/1", w);
    end
    total++;
    if ({len_err, len_err16, m_tvalid, s_tready} !== 4'b1001) begin
      bad++;
      $display("FAIL exact_after: err/err16/valid/ready=%b required 1001", {len_err, len_err16, m_tvalid, s_tready});
    end
  endtask

  task automatic test_backpressure();
    logic [21:0] w, w16;
    send_beat(16'hAAAA, 5'd16, 1'b0);
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({m_tvalid, m_tdata, m_tkeep, m_tlast, s_tready} !== {1'b1, 16'hAAAA, 5'd16, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL bp_hold%0d: got v=%b d=%h k=%0d l=%b r=%b required 1/aaaa/16/0/0",
                 i, m_tvalid, m_tdata, m_tkeep, m_tlast, s_tready);
      end
      @(negedge clk);
    end
    get_word(0, w, w16);
    total++;
    if (w !== {16'hAAAA, 5'd16, 1'b0}) begin
      bad++;
      $display("FAIL bp_w0: got %h required aaaa/16/0", w);
    end
    send_beat(16'h5555, 5'd16, 1'b0);
    get_word(0, w, w16);
    total++;
    if (w !== {16'h5555, 5'd16, 1'b0}) begin
      bad++;
      $display("FAIL bp_w1: got %h required 5555/16/0", w);
    end
    send_beat(16'h00C3, 5'd8, 1'b1);
    get_word(0, w, w16);
    total++;
    if ({w, len_err} !== {16'h00C3, 5'd8, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL bp_w2: got %h err=%b required 00c3/8/1 err=0", w, len_err);
    end
  endtask

  task automatic test_illegal_keep();
    logic [21:0] w, w16;
    send_beat(16'hFFFF, 5'd20, 1'b1);
    get_word(0, w, w16);
    total++;
    if (w16 !== {16'hFFFF, 5'd16, 1'b1}) begin
      bad++;
      $display("FAIL illegal_w0: got %h required ffff/16/1", w16);
    end
    total++;
    if ({len_err16, len_err} !== 2'b11) begin
      bad++;
      $display("FAIL illegal_len_err: got %b required 11", {len_err16, len_err});
    end
    @(negedge clk);
    total++;
    if (len_err16 !== 1'b0) begin
      bad++;
      $display("FAIL illegal_pulse: len_err16=%b required 0", len_err16);
    end
  endtask

  task automatic test_reset_mid();
    send_beat(16'hAAAA, 5'd16, 1'b0);
    reset_n = 1'b0;
    @(negedge clk);
    total++;
    if ({m_tvalid, s_tready, m_tvalid16} !== 3'b000) begin
      bad++;
      $display("FAIL reset_mid: valid/ready/valid16=%b required 000", {m_tvalid, s_tready, m_tvalid16});
    end
    reset_n = 1'b1;
    @(negedge clk);
    test_basic();
  endtask

  task automatic test_random();
    bit          q[$];
    logic [21:0] exp_q[$];
    logic [21:0] w, w16, e;
    logic [15:0] d, word;
    logic [4:0]  keep;
    int unsigned k, nb, n, pkt_bits;
    bit          illegal, last, emitted;
    for (int p = 0; p < 40; p++) begin
      nb       = $urandom_range(1, 5);
      pkt_bits = 0;
      illegal  = 0;
      for (int b = 0; b < int'(nb); b++) begin
        d    = 16'($urandom);
        keep = ($urandom_range(0, 19) == 0) ? 5'($urandom_range(17, 31)) : 5'($urandom_range(0, 16));
        last = (b == int'(nb) - 1);
        k    = (keep > 5'd16) ? 16 : int'(keep);
        if (keep > 5'd16) illegal = 1;
        for (int i = 0; i < int'(k); i++) q.push_back(d[i]);
        pkt_bits += k;
        emitted = 0;
        if (q.size() >= 16) begin
          word = '0;
          for (int i = 0; i < 16; i++) word[i] = q.pop_front();
          exp_q.push_back({word, 5'd16, last && (q.size() == 0)});
          emitted = 1;
        end
        if (last && !(emitted && q.size() == 0)) begin
          word = '0;
          n    = q.size();
          for (int i = 0; i < int'(n); i++) word[i] = q.pop_front();
          exp_q.push_back({word, 5'(n), 1'b1});
        end
        send_beat(d, keep, last);
        if (exp_q.size() == 0) begin
          total++;
          if (m_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL rand_spurious p%0d b%0d: m_tvalid=%b required 0", p, b, m_tvalid);
          end
        end
        while (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          get_word($urandom_range(0, 3), w, w16);
          total++;
          if ({w, w16} !== {e, e}) begin
            bad++;
            $display("FAIL rand_word p%0d b%0d: got %h/%h required %h", p, b, w, w16, e);
          end
        end
      end
      total++;
      if ({len_err, len_err16} !== {(pkt_bits != 40) || illegal, (pkt_bits != 16) || illegal}) begin
        bad++;
        $display("FAIL rand_len_err p%0d: got %b required %b%b (bits=%0d illegal=%0d)", p,
                 {len_err, len_err16}, (pkt_bits != 40) || illegal, (pkt_bits != 16) || illegal,
                 pkt_bits, illegal);
      end
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b0;
    test_reset();
    test_basic();
    test_straddle();
    test_exact_fill();
    test_backpressure();
    test_illegal_keep();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
